// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the front-panel program loader and the blocks that
// talk to it (CPU controller, memory, display).
//   CS_*    : cpustate mode encodings driven by the CPU controller
//   state_t : loader FSM state encoding
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  localparam logic [1:0] CS_IDLE  = 2'b00;
  localparam logic [1:0] CS_PROG  = 2'b01;
  localparam logic [1:0] CS_CHECK = 2'b10;
  localparam logic [1:0] CS_RUN   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STROBE   = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

endpackage

// File: rtl/prog_loader_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Debounces the raw step key. The debounced level flips only after the raw
// input has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_raw      : raw key input (already synchronous to clk)
//   o_db       : debounced level
//   o_rise     : one-cycle pulse on a debounced rising edge
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_db,
  output logic o_rise
);

  // Counter value on which the flip happens; the flip edge is the
  // DEBOUNCE_CYCLES-th consecutive disagreeing edge.
  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  logic [7:0] r_cnt;
  logic       r_db;
  logic       r_db_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 8'd0;
      r_db   <= 1'b0;
      r_db_q <= 1'b0;
    end else begin
      r_db_q <= r_db;
      if (i_raw == r_db) begin
        r_cnt <= 8'd0;
      end else if (r_cnt == LAST_CNT) begin
        r_db  <= i_raw;
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_db & ~r_db_q;

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Front-panel program loader. Each debounced press of the step key A1 issues
// one memory write (program mode) or one memory read (check mode) at the
// current address, then advances the address. The key must be released
// before the next press is accepted.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   cpustate  : 00 idle, 01 program, 10 check, 11 run
//   A1        : raw step key
//   D         : switch data word
//   ld_addr   : current load/check address
//   ld_data   : D captured when the strobe is issued
//   ld_write  : one-cycle write strobe (program mode)
//   ld_read   : one-cycle read strobe (check mode)
//   wr_count  : writes since entering program mode, saturating at 2^ADDR_W
//   busy      : FSM is not idle
// Handshake: ld_write/ld_read are single-cycle strobes with no back-pressure;
// the memory must accept a strobe in the cycle it is high.
// -----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADDR_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cpustate,
  input  logic              A1,
  input  logic [7:0]        D,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [7:0]        ld_data,
  output logic              ld_write,
  output logic              ld_read,
  output logic [ADDR_W:0]   wr_count,
  output logic              busy
);

  localparam logic [ADDR_W:0] WR_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_cs;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_data;
  logic                r_wr_stb;
  logic                r_rd_stb;
  logic [ADDR_W:0]     r_wr_count;
  logic                r_busy;
  logic                w_db;
  logic                w_rise;
  logic                w_mode_chg;
  logic                w_write;
  logic                w_read;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (A1),
    .o_db   (w_db),
    .o_rise (w_rise)
  );

  // A mode change aborts whatever is in flight, including a strobe that is
  // already registered for this cycle.
  assign w_mode_chg = (cpustate != r_cs);
  assign w_write    = r_wr_stb & ~w_mode_chg;
  assign w_read     = r_rd_stb & ~w_mode_chg;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rise && (cpustate == CS_PROG || cpustate == CS_CHECK)) begin
          w_next = S_STROBE;
        end
      end
      S_STROBE:   w_next = S_WAIT_REL;
      S_WAIT_REL: begin
        if (!w_db) begin
          w_next = S_IDLE;
        end
      end
      default:    w_next = S_IDLE;
    endcase
    if (w_mode_chg) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cs       <= CS_IDLE;
      r_addr     <= '0;
      r_data     <= 8'd0;
      r_wr_stb   <= 1'b0;
      r_rd_stb   <= 1'b0;
      r_wr_count <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cs     <= cpustate;
      r_busy   <= (w_next != S_IDLE);
      // Strobes are registered on entry to S_STROBE so they are high for
      // exactly the one cycle the FSM spends there.
      r_wr_stb <= (w_next == S_STROBE) && (cpustate == CS_PROG);
      r_rd_stb <= (w_next == S_STROBE) && (cpustate == CS_CHECK);
      if (w_next == S_STROBE) begin
        r_data <= D;
      end

      if (w_mode_chg || r_cs == CS_RUN) begin
        r_addr <= '0;
      end else if (r_state == S_STROBE) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

      if (w_mode_chg) begin
        r_wr_count <= '0;
      end else if (w_write && r_wr_count != WR_MAX) begin
        r_wr_count <= r_wr_count + (ADDR_W + 1)'(1);
      end
    end
  end

  assign ld_addr  = r_addr;
  assign ld_data  = r_data;
  assign ld_write = w_write;
  assign ld_read  = w_read;
  assign wr_count = r_wr_count;
  assign busy     = r_busy;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Directed bench for prog_loader with a strobe scoreboard. Expected strobes
// ({is_write, addr, data}) are queued when a press is driven and popped by a
// monitor on every observed strobe.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  logic       clk;
  logic       rst;
  logic [1:0] cpustate;
  logic       A1;
  logic [7:0] D;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_write;
  logic       ld_read;
  logic [8:0] wr_count;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  exp_addr;

  prog_loader #(
    .DEBOUNCE_CYCLES(4),
    .ADDR_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpustate (cpustate),
    .A1       (A1),
    .D        (D),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_write (ld_write),
    .ld_read  (ld_read),
    .wr_count (wr_count),
    .busy     (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One clean press: held well past the debounce time, then fully released.
  task automatic press();
    A1 = 1'b1;
    tick(8);
    A1 = 1'b0;
    tick(8);
  endtask

  task automatic push_exp(input logic is_wr, input logic [7:0] addr, input logic [7:0] data);
    exp_q.push_back({is_wr, addr, data});
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [16:0] item;
    if (ld_write && ld_read) begin
      check("both_strobes", 32'({ld_write, ld_read}), 32'd0);
    end
    if (ld_write || ld_read) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_strobe: observed write=%0b read=%0b addr=%0h expected no strobe",
               ld_write, ld_read, ld_addr);
      end
      if (exp_q.size() != 0) begin
        item = exp_q.pop_front();
        check("sb_kind", 32'(ld_write), 32'(item[16]));
        check("sb_addr", 32'(ld_addr), 32'(item[15:8]));
        if (item[16]) begin
          check("sb_data", 32'(ld_data), 32'(item[7:0]));
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    cpustate = 2'b00;
    A1       = 1'b0;
    D        = 8'h00;
    tick(3);

    // Reset state
    check("rst_addr",  32'(ld_addr),  32'd0);
    check("rst_data",  32'(ld_data),  32'd0);
    check("rst_write", 32'(ld_write), 32'd0);
    check("rst_read",  32'(ld_read),  32'd0);
    check("rst_wrcnt", 32'(wr_count), 32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    rst = 1'b0;
    tick(2);

    // Single write with exact latency
    cpustate = 2'b01;
    D = 8'h3C;
    tick(2);
    push_exp(1'b1, 8'h00, 8'h3C);
    A1 = 1'b1;
    tick(4);
    check("lat_early_write", 32'(ld_write), 32'd0);
    tick(1);
    check("lat_write", 32'(ld_write), 32'd1);
    check("lat_addr",  32'(ld_addr),  32'd0);
    check("lat_data",  32'(ld_data),  32'h3C);
    check("lat_busy",  32'(busy),     32'd1);
    tick(1);
    check("post_write", 32'(ld_write), 32'd0);
    check("post_addr",  32'(ld_addr),  32'd1);
    check("post_wrcnt", 32'(wr_count), 32'd1);
    A1 = 1'b0;
    tick(8);
    check("release_busy", 32'(busy), 32'd0);

    // Glitch shorter than the debounce time
    A1 = 1'b1;
    tick(3);
    A1 = 1'b0;
    tick(8);
    check("glitch_addr",  32'(ld_addr),  32'd1);
    check("glitch_wrcnt", 32'(wr_count), 32'd1);
    check("glitch_busy",  32'(busy),     32'd0);

    // Check mode: three reads
    cpustate = 2'b10;
    tick(2);
    check("chk_addr_clr", 32'(ld_addr), 32'd0);
    exp_addr = 8'd0;
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, exp_addr, 8'h00);
      press();
      exp_addr = exp_addr + 8'd1;
    end
    check("chk_addr",  32'(ld_addr),  32'd3);
    check("chk_wrcnt", 32'(wr_count), 32'd0);
    check("chk_q_empty", 32'(exp_q.size()), 32'd0);

    // Program mode: full wrap and wr_count saturation
    cpustate = 2'b01;
    tick(2);
    check("prog_addr_clr", 32'(ld_addr), 32'd0);
    exp_addr = 8'd0;
    for (int i = 0; i < 256; i++) begin
      D = 8'($urandom_range(0, 255));
      push_exp(1'b1, exp_addr, D);
      press();
      exp_addr = exp_addr + 8'd1;
    end
    check("wrap_addr",  32'(ld_addr),  32'd0);
    check("wrap_wrcnt", 32'(wr_count), 32'd256);
    D = 8'($urandom_range(0, 255));
    push_exp(1'b1, 8'h00, D);
    press();
    check("sat_addr",  32'(ld_addr),  32'd1);
    check("sat_wrcnt", 32'(wr_count), 32'd256);
    check("prog_q_empty", 32'(exp_q.size()), 32'd0);

    // Mode change in the strobe cycle
    A1 = 1'b1;
    tick(5);
    cpustate = 2'b10;
    #1;
    check("mchg_write", 32'(ld_write), 32'd0);
    check("mchg_read",  32'(ld_read),  32'd0);
    tick(1);
    check("mchg_addr",  32'(ld_addr),  32'd0);
    check("mchg_busy",  32'(busy),     32'd0);
    check("mchg_wrcnt", 32'(wr_count), 32'd0);
    A1 = 1'b0;
    tick(8);

    // Run mode ignores presses
    cpustate = 2'b11;
    tick(2);
    press();
    check("run_addr", 32'(ld_addr), 32'd0);
    check("run_busy", 32'(busy),    32'd0);

    // Reset while the key is held
    cpustate = 2'b01;
    D = 8'hA5;
    tick(2);
    A1 = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);
    check("hrst_addr",  32'(ld_addr),  32'd0);
    check("hrst_data",  32'(ld_data),  32'd0);
    check("hrst_write", 32'(ld_write), 32'd0);
    check("hrst_read",  32'(ld_read),  32'd0);
    check("hrst_wrcnt", 32'(wr_count), 32'd0);
    check("hrst_busy",  32'(busy),     32'd0);
    rst = 1'b0;
    tick(4);
    check("hrst_early_write", 32'(ld_write), 32'd0);
    push_exp(1'b1, 8'h00, 8'hA5);
    tick(1);
    check("hrst_write_pulse", 32'(ld_write), 32'd1);
    check("hrst_write_addr",  32'(ld_addr),  32'd0);
    tick(1);
    check("hrst_post_addr",  32'(ld_addr),  32'd1);
    check("hrst_post_wrcnt", 32'(wr_count), 32'd1);
    A1 = 1'b0;
    tick(8);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
